// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl
//   Bus-side register controller for the AHB UART. It accepts single-beat
//   reads and writes, decodes them against the UART register map, and
//   sequences TX FIFO pushes and RX FIFO pops. A blocked push or pop stalls
//   for a bounded number of cycles before it is answered with an error. The
//   block also owns the baud-divisor register.
//
//   Register map (word aligned, every other address is unmapped):
//     0x00 RX data    RO
//     0x04 TX data    WO
//     0x08 RX status  RO  {zero, rx_count, 6'b0, rx_full, rx_empty}
//     0x0C TX status  RO  {zero, tx_count, 6'b0, tx_full, tx_empty}
//     0x10 baud div   RW  zero-extended on read, writing 0 is illegal
//
// Ports
//   clk, nReset                  clock, asynchronous active-low reset
//   bus_addr/wen/ren/wdata       request, sampled only while idle
//   bus_rdata/ready/error        one-cycle response strobe with data/error
//   tx_push, tx_data             TX FIFO write side
//   tx_full, tx_empty, tx_count  TX FIFO flags and occupancy
//   rx_pop, rx_data              RX FIFO read side (show-ahead head data)
//   rx_full, rx_empty, rx_count  RX FIFO flags and occupancy
//   baud_div, baud_load          baud divisor and its update strobe
module uart_bus_ctrl #(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 8,
  parameter int BAUD_W   = 16,
  parameter int BAUD_RST = 434,
  parameter int WAIT_MAX = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [31:0]       bus_addr,
  input  logic              bus_wen,
  input  logic              bus_ren,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  output logic              bus_error,
  output logic              tx_push,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_full,
  input  logic              tx_empty,
  input  logic [CNT_W-1:0]  tx_count,
  output logic              rx_pop,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_full,
  input  logic              rx_empty,
  input  logic [CNT_W-1:0]  rx_count,
  output logic [BAUD_W-1:0] baud_div,
  output logic              baud_load
);

  localparam int                WCNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_RXD  = 3'd0,
    OP_TXD  = 3'd1,
    OP_RXS  = 3'd2,
    OP_TXS  = 3'd3,
    OP_BAUD = 3'd4,
    OP_NONE = 3'd5
  } op_t;

  // Exact-match decode: misaligned or out-of-range addresses fall to OP_NONE.
  function automatic op_t decode_addr(input logic [31:0] addr);
    op_t res;
    case (addr)
      32'h0000_0000: res = OP_RXD;
      32'h0000_0004: res = OP_TXD;
      32'h0000_0008: res = OP_RXS;
      32'h0000_000C: res = OP_TXS;
      32'h0000_0010: res = OP_BAUD;
      default:       res = OP_NONE;
    endcase
    return res;
  endfunction

  // A request is legal only with exactly one direction, matching the
  // register's access type; a zero baud divisor would stall the UART.
  function automatic logic req_legal(input op_t op_in, input logic wen,
                                     input logic ren,
                                     input logic [BAUD_W-1:0] wbaud);
    logic ok;
    if (wen && ren) begin
      ok = 1'b0;
    end else begin
      case (op_in)
        OP_RXD, OP_RXS, OP_TXS: ok = ren;
        OP_TXD:                 ok = wen;
        OP_BAUD:                ok = ren || (wen && (wbaud != {BAUD_W{1'b0}}));
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [31:0] status_word(input logic [CNT_W-1:0] cnt,
                                              input logic full,
                                              input logic empty);
    return 32'({cnt, 6'b00_0000, full, empty});
  endfunction

  state_t            state;
  op_t               op;
  op_t               req_op;
  logic              is_write;
  logic [WCNT_W-1:0] wait_cnt;
  logic              unused_wdata;

  // Upper write-data bits have no destination in any register.
  assign unused_wdata = ^bus_wdata[31:BAUD_W];

  // Decode of the incoming address, only consumed while idle.
  always_comb begin
    req_op = decode_addr(bus_addr);
  end

  // FIFO strobes follow the live full/empty flag during ACCESS and WAIT so a
  // flag that clears in a cycle is acted on in that same cycle.
  always_comb begin
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    if ((state == S_ACCESS) || (state == S_WAIT)) begin
      tx_push = (op == OP_TXD) && !tx_full;
      rx_pop  = (op == OP_RXD) && !rx_empty;
    end else begin
      tx_push = 1'b0;
      rx_pop  = 1'b0;
    end
  end

  // Main request sequencer with registered bus response and baud register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      op        <= OP_NONE;
      is_write  <= 1'b0;
      wait_cnt  <= {WCNT_W{1'b0}};
      bus_rdata <= 32'h0000_0000;
      bus_ready <= 1'b0;
      bus_error <= 1'b0;
      tx_data   <= {DATA_W{1'b0}};
      baud_div  <= BAUD_W'(BAUD_RST);
      baud_load <= 1'b0;
    end else begin
      // Response and load strobes last exactly one cycle.
      bus_rdata <= 32'h0000_0000;
      bus_ready <= 1'b0;
      bus_error <= 1'b0;
      baud_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus_wen || bus_ren) begin
            if (req_legal(req_op, bus_wen, bus_ren, bus_wdata[BAUD_W-1:0])) begin
              state    <= S_ACCESS;
              op       <= req_op;
              is_write <= bus_wen;
              if (req_op == OP_TXD) begin
                tx_data <= bus_wdata[DATA_W-1:0];
              end
              // Baud update becomes visible in the ACCESS cycle.
              if ((req_op == OP_BAUD) && bus_wen) begin
                baud_div  <= bus_wdata[BAUD_W-1:0];
                baud_load <= 1'b1;
              end
            end else begin
              state     <= S_ERROR;
              bus_ready <= 1'b1;
              bus_error <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          case (op)
            OP_RXS: begin
              bus_rdata <= status_word(rx_count, rx_full, rx_empty);
              bus_ready <= 1'b1;
              state     <= S_RESP;
            end
            OP_TXS: begin
              bus_rdata <= status_word(tx_count, tx_full, tx_empty);
              bus_ready <= 1'b1;
              state     <= S_RESP;
            end
            OP_BAUD: begin
              bus_rdata <= is_write ? 32'h0000_0000 : 32'(baud_div);
              bus_ready <= 1'b1;
              state     <= S_RESP;
            end
            OP_TXD: begin
              if (!tx_full) begin
                bus_ready <= 1'b1;
                state     <= S_RESP;
              end else begin
                wait_cnt <= {WCNT_W{1'b0}};
                state    <= S_WAIT;
              end
            end
            OP_RXD: begin
              if (!rx_empty) begin
                bus_rdata <= 32'(rx_data);
                bus_ready <= 1'b1;
                state     <= S_RESP;
              end else begin
                wait_cnt <= {WCNT_W{1'b0}};
                state    <= S_WAIT;
              end
            end
            default: begin
              bus_ready <= 1'b1;
              bus_error <= 1'b1;
              state     <= S_ERROR;
            end
          endcase
        end
        S_WAIT: begin
          // An unblocked FIFO in the last wait cycle still completes normally.
          if (tx_push) begin
            bus_ready <= 1'b1;
            state     <= S_RESP;
          end else if (rx_pop) begin
            bus_rdata <= 32'(rx_data);
            bus_ready <= 1'b1;
            state     <= S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            bus_ready <= 1'b1;
            bus_error <= 1'b1;
            state     <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        S_ERROR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb_uart_bus_ctrl
//   Directed bench for uart_bus_ctrl: a table of single-request vectors with
//   hand-computed responses, followed by hand-written sequences for stalls,
//   timeout, ignored requests and reset in the middle of a wait.
module tb_uart_bus_ctrl;

  logic        clk = 1'b0;
  logic        nReset;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_error;
  logic        tx_push;
  logic [7:0]  tx_data;
  logic        tx_full;
  logic        tx_empty;
  logic [7:0]  tx_count;
  logic        rx_pop;
  logic [7:0]  rx_data;
  logic        rx_full;
  logic        rx_empty;
  logic [7:0]  rx_count;
  logic [15:0] baud_div;
  logic        baud_load;

  uart_bus_ctrl dut (
    .clk(clk), .nReset(nReset),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .bus_error(bus_error), .tx_push(tx_push), .tx_data(tx_data),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_count(tx_count),
    .rx_pop(rx_pop), .rx_data(rx_data), .rx_full(rx_full),
    .rx_empty(rx_empty), .rx_count(rx_count), .baud_div(baud_div),
    .baud_load(baud_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic        txf;
    logic        txe;
    logic [7:0]  txc;
    logic        rxf;
    logic        rxe;
    logic [7:0]  rxc;
    logic [7:0]  rxd;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          push;
    int          pop;
    int          load;
    logic [7:0]  txd;
  } vec_t;

  vec_t vecs[18];

  int n_cmp  = 0;
  int n_fail = 0;

  // Results of the most recent observed request.
  int          o_lat, o_push, o_pop, o_load, o_push_c, o_pop_c;
  logic        o_err, o_both;
  logic [31:0] o_rdata;
  logic [7:0]  o_txd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w, input logic r,
                           input logic [31:0] d);
    bus_addr  = a;
    bus_wen   = w;
    bus_ren   = r;
    bus_wdata = d;
  endtask

  // Cycle c counts clock edges after the request edge. At cycle rel_c both
  // FIFO blocking flags are released. Stops at bus_ready or after max_c.
  task automatic observe(input int rel_c, input int max_c);
    o_lat = 0; o_err = 1'b0; o_rdata = 32'h0; o_push = 0; o_pop = 0;
    o_load = 0; o_push_c = 0; o_pop_c = 0; o_txd = 8'h00; o_both = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus_wen = 1'b0;
        bus_ren = 1'b0;
      end
      if (c == rel_c) begin
        tx_full  = 1'b0;
        rx_empty = 1'b0;
      end
      #1;
      if (tx_push) begin o_push++; o_push_c = c; o_txd = tx_data; end
      if (rx_pop) begin o_pop++; o_pop_c = c; end
      if (tx_push && rx_pop) o_both = 1'b1;
      if (baud_load) o_load++;
      if (bus_ready) begin
        o_lat   = c;
        o_err   = bus_error;
        o_rdata = bus_rdata;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            addr  wen  ren  wdata         txf  txe  txc   rxf  rxe  rxc    rxd    lat err rdata         push pop load txd
    vecs[0]  = '{32'h10, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0,  8'h00, 2, 1'b0, 32'd434,      0, 0, 0, 8'h00};
    vecs[1]  = '{32'h04, 1'b1, 1'b0, 32'h41,       1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0,  8'h00, 2, 1'b0, 32'h0,        1, 0, 0, 8'h41};
    vecs[2]  = '{32'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd1,  8'h5A, 2, 1'b0, 32'h5A,       0, 1, 0, 8'h00};
    vecs[3]  = '{32'h08, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd3,  8'h00, 2, 1'b0, 32'h0000_0300, 0, 0, 0, 8'h00};
    vecs[4]  = '{32'h0C, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 8'd5, 1'b0, 1'b1, 8'd0,  8'h00, 2, 1'b0, 32'h0000_0502, 0, 0, 0, 8'h00};
    vecs[5]  = '{32'h0C, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 8'd8,  8'h00, 2, 1'b0, 32'h0000_0001, 0, 0, 0, 8'h00};
    vecs[6]  = '{32'h08, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 8'h10, 8'h00, 2, 1'b0, 32'h0000_1002, 0, 0, 0, 8'h00};
    vecs[7]  = '{32'h04, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd1,  8'h22, 1, 1'b1, 32'h0,        0, 0, 0, 8'h00};
    vecs[8]  = '{32'h08, 1'b1, 1'b0, 32'hFF,       1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd1,  8'h22, 1, 1'b1, 32'h0,        0, 0, 0, 8'h00};
    vecs[9]  = '{32'h14, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd1,  8'h22, 1, 1'b1, 32'h0,        0, 0, 0, 8'h00};
    vecs[10] = '{32'h02, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd1,  8'h22, 1, 1'b1, 32'h0,        0, 0, 0, 8'h00};
    vecs[11] = '{32'h04, 1'b1, 1'b1, 32'h33,       1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd1,  8'h22, 1, 1'b1, 32'h0,        0, 0, 0, 8'h00};
    vecs[12] = '{32'h10, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0,  8'h00, 1, 1'b1, 32'h0,        0, 0, 0, 8'h00};
    vecs[13] = '{32'h10, 1'b1, 1'b0, 32'h1B2,      1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0,  8'h00, 2, 1'b0, 32'h0,        0, 0, 1, 8'h00};
    vecs[14] = '{32'h10, 1'b1, 1'b0, 32'hFFFF_1234, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0, 8'h00, 2, 1'b0, 32'h0,        0, 0, 1, 8'h00};
    vecs[15] = '{32'h10, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0,  8'h00, 2, 1'b0, 32'h0000_1234, 0, 0, 0, 8'h00};
    vecs[16] = '{32'h10, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0, 8'h00, 1, 1'b1, 32'h0,        0, 0, 0, 8'h00};
    vecs[17] = '{32'h10, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0,  8'h00, 2, 1'b0, 32'h0000_1234, 0, 0, 0, 8'h00};

    nReset = 1'b0;
    drive_req(32'h0, 1'b0, 1'b0, 32'h0);
    tx_full = 1'b0; tx_empty = 1'b1; tx_count = 8'd0;
    rx_full = 1'b0; rx_empty = 1'b1; rx_count = 8'd0; rx_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus_ready), 32'd0);
    chk("rst_error", 32'(bus_error), 32'd0);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_push", 32'(tx_push), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    chk("rst_pop", 32'(rx_pop), 32'd0);
    chk("rst_load", 32'(baud_load), 32'd0);
    chk("rst_baud", 32'(baud_div), 32'd434);
    nReset = 1'b1;
    @(posedge clk); #1;

    // Table of single requests
    for (int i = 0; i < 18; i++) begin
      tx_full = vecs[i].txf; tx_empty = vecs[i].txe; tx_count = vecs[i].txc;
      rx_full = vecs[i].rxf; rx_empty = vecs[i].rxe; rx_count = vecs[i].rxc;
      rx_data = vecs[i].rxd;
      drive_req(vecs[i].addr, vecs[i].wen, vecs[i].ren, vecs[i].wdata);
      observe(0, 8);
      chk($sformatf("v%0d_latency", i), 32'(o_lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_error", i), 32'(o_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_rdata", i), o_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_pushes", i), 32'(o_push), 32'(vecs[i].push));
      chk($sformatf("v%0d_pops", i), 32'(o_pop), 32'(vecs[i].pop));
      chk($sformatf("v%0d_loads", i), 32'(o_load), 32'(vecs[i].load));
      if (vecs[i].push > 0) begin
        chk($sformatf("v%0d_txdata", i), 32'(o_txd), 32'(vecs[i].txd));
        chk($sformatf("v%0d_push_cycle", i), 32'(o_push_c), 32'd1);
      end
      if (vecs[i].pop > 0) begin
        chk($sformatf("v%0d_pop_cycle", i), 32'(o_pop_c), 32'd1);
      end
      @(posedge clk); #1;
    end
    tx_full = 1'b0; tx_empty = 1'b1; tx_count = 8'd0;
    rx_full = 1'b0; rx_empty = 1'b1; rx_count = 8'd0;

    // TX blocked, released in the second wait cycle
    tx_full = 1'b1;
    drive_req(32'h04, 1'b1, 1'b0, 32'h77);
    observe(3, 10);
    chk("txrel_latency", 32'(o_lat), 32'd4);
    chk("txrel_error", 32'(o_err), 32'd0);
    chk("txrel_pushes", 32'(o_push), 32'd1);
    chk("txrel_push_cycle", 32'(o_push_c), 32'd3);
    chk("txrel_txdata", 32'(o_txd), 32'h77);
    @(posedge clk); #1;

    // TX blocked for the whole wait budget
    tx_full = 1'b1;
    drive_req(32'h04, 1'b1, 1'b0, 32'h88);
    observe(0, 10);
    chk("txto_latency", 32'(o_lat), 32'd6);
    chk("txto_error", 32'(o_err), 32'd1);
    chk("txto_rdata", o_rdata, 32'h0);
    chk("txto_pushes", 32'(o_push), 32'd0);
    tx_full = 1'b0;
    @(posedge clk); #1;

    // RX unblocked in the last allowed wait cycle
    rx_empty = 1'b1; rx_data = 8'hC3;
    drive_req(32'h00, 1'b0, 1'b1, 32'h0);
    observe(5, 10);
    chk("rxlast_latency", 32'(o_lat), 32'd6);
    chk("rxlast_error", 32'(o_err), 32'd0);
    chk("rxlast_pops", 32'(o_pop), 32'd1);
    chk("rxlast_pop_cycle", 32'(o_pop_c), 32'd5);
    chk("rxlast_rdata", o_rdata, 32'hC3);
    chk("rxlast_both", 32'(o_both), 32'd0);
    rx_empty = 1'b1;
    @(posedge clk); #1;

    // Baud write with a second request presented while busy
    drive_req(32'h10, 1'b1, 1'b0, 32'h55);
    @(posedge clk); #1;
    rx_empty = 1'b0; rx_data = 8'h11;
    drive_req(32'h00, 1'b0, 1'b1, 32'h0);
    #1;
    chk("busy_load", 32'(baud_load), 32'd1);
    chk("busy_baud", 32'(baud_div), 32'h55);
    chk("busy_pop_access", 32'(rx_pop), 32'd0);
    @(posedge clk); #1;
    bus_ren = 1'b0;
    #1;
    chk("busy_ready", 32'(bus_ready), 32'd1);
    chk("busy_error", 32'(bus_error), 32'd0);
    chk("busy_load_off", 32'(baud_load), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk($sformatf("busy_no_ready_%0d", k), 32'(bus_ready), 32'd0);
      chk($sformatf("busy_no_pop_%0d", k), 32'(rx_pop), 32'd0);
    end
    rx_empty = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while an RX read waits
    drive_req(32'h00, 1'b0, 1'b1, 32'h0);
    @(posedge clk); #1;
    bus_ren = 1'b0;
    @(posedge clk); #1;
    nReset = 1'b0;
    #1;
    chk("mrst_ready", 32'(bus_ready), 32'd0);
    chk("mrst_error", 32'(bus_error), 32'd0);
    chk("mrst_rdata", bus_rdata, 32'h0);
    chk("mrst_push", 32'(tx_push), 32'd0);
    chk("mrst_txdata", 32'(tx_data), 32'd0);
    chk("mrst_load", 32'(baud_load), 32'd0);
    chk("mrst_baud", 32'(baud_div), 32'd434);
    rx_empty = 1'b0; rx_data = 8'h99;
    #1;
    chk("mrst_pop", 32'(rx_pop), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      chk($sformatf("mrst_hold_pop_%0d", k), 32'(rx_pop), 32'd0);
      chk($sformatf("mrst_hold_ready_%0d", k), 32'(bus_ready), 32'd0);
    end
    nReset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk($sformatf("mrst_after_pop_%0d", k), 32'(rx_pop), 32'd0);
      chk($sformatf("mrst_after_ready_%0d", k), 32'(bus_ready), 32'd0);
    end
    rx_empty = 1'b1;
    @(posedge clk); #1;

    // Baud divisor reads back its reset value after the abort
    drive_req(32'h10, 1'b0, 1'b1, 32'h0);
    observe(0, 8);
    chk("post_latency", 32'(o_lat), 32'd2);
    chk("post_rdata", o_rdata, 32'd434);
    chk("post_error", 32'(o_err), 32'd0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
